// File: rtl/dm_spi_frame_sequencer_if.sv
// Bundle between the frame sequencer and its environment (channel buffer RAM,
// per-bus SPI shifters, frame trigger and status registers).
interface dm_spi_frame_sequencer_if #(
  parameter int NUM_BUS = 6,
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 5
);
  logic                        Start;
  logic                        ClrFlags;
  logic [ADDR_W-1:0]           RdAddr;
  logic [DATA_W-1:0]           RdData;
  logic [NUM_BUS*DATA_W-1:0]   SpiData;
  logic [1:0]                  SpiCsSel;
  logic                        SpiGo;
  logic [NUM_BUS-1:0]          SpiBusy;
  logic                        Busy;
  logic                        FrameDone;
  logic                        Fault;
  logic [1:0]                  FaultCs;
  logic                        Overrun;

  // Sequencer side.
  modport master (
    input  Start, ClrFlags, RdData, SpiBusy,
    output RdAddr, SpiData, SpiCsSel, SpiGo, Busy, FrameDone, Fault, FaultCs, Overrun
  );

  // Environment side: trigger source, buffer RAM, shifters.
  modport slave (
    output Start, ClrFlags, RdData, SpiBusy,
    input  RdAddr, SpiData, SpiCsSel, SpiGo, Busy, FrameDone, Fault, FaultCs, Overrun
  );
endinterface

// File: rtl/dm_spi_frame_sequencer.sv
// Walks chip-select slots 0..NUM_CS-1 of one deformable-mirror update frame:
// fetch one word per bus from the channel buffer, launch all shifters, wait, gap.
module dm_spi_frame_sequencer #(
  parameter int NUM_BUS        = 6,
  parameter int NUM_CS         = 4,
  parameter int DATA_W         = 24,
  parameter int ADDR_W         = 5,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                      clk,
  input logic                      nRst,
  dm_spi_frame_sequencer_if.master ctl_if
);

  localparam int IDX_W  = $clog2(NUM_BUS + 1);
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GCNT_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic [1:0]                cs_q;
  logic [IDX_W-1:0]          idx_q;
  logic [WCNT_W-1:0]         wcnt_q;
  logic [GCNT_W-1:0]         gcnt_q;
  logic [ADDR_W-1:0]         rd_addr_q;
  logic [NUM_BUS*DATA_W-1:0] spi_data_q;
  logic [1:0]                spi_cs_sel_q;
  logic                      spi_go_q;
  logic                      busy_q;
  logic                      frame_done_q;
  logic                      fault_q;
  logic [1:0]                fault_cs_q;
  logic                      overrun_q;

  logic                      overrun_set_d;
  logic                      timeout_d;
  logic                      shifters_idle_d;

  function automatic logic [ADDR_W-1:0] slot_base(input logic [1:0] cs);
    return ADDR_W'(int'(cs) * NUM_BUS);
  endfunction

  // Any Start outside IDLE (DONE included) is a request we cannot honour.
  assign overrun_set_d   = ctl_if.Start && (state_q != S_IDLE);
  assign shifters_idle_d = ~|ctl_if.SpiBusy;
  assign timeout_d       = (state_q == S_WAIT) && !shifters_idle_d &&
                           (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= S_IDLE;
      cs_q         <= 2'd0;
      idx_q        <= '0;
      wcnt_q       <= '0;
      gcnt_q       <= '0;
      rd_addr_q    <= '0;
      spi_data_q   <= '0;
      spi_cs_sel_q <= 2'd0;
      spi_go_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_cs_q   <= 2'd0;
      overrun_q    <= 1'b0;
    end else begin
      spi_go_q     <= 1'b0;
      frame_done_q <= 1'b0;

      // Sticky flags: a set event in the same cycle as ClrFlags wins.
      if (overrun_set_d)        overrun_q <= 1'b1;
      else if (ctl_if.ClrFlags) overrun_q <= 1'b0;

      if (timeout_d) begin
        fault_q    <= 1'b1;
        fault_cs_q <= cs_q;
      end else if (ctl_if.ClrFlags) begin
        fault_q    <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (ctl_if.Start) begin
            state_q   <= S_LOAD;
            cs_q      <= 2'd0;
            idx_q     <= '0;
            rd_addr_q <= slot_base(2'd0);
            busy_q    <= 1'b1;
          end
        end

        // idx_q counts LOAD cycles; word for bus b arrives while idx_q == b+1.
        S_LOAD: begin
          for (int b = 0; b < NUM_BUS; b++) begin
            if (idx_q == IDX_W'(b + 1)) spi_data_q[b*DATA_W +: DATA_W] <= ctl_if.RdData;
          end
          if (idx_q < IDX_W'(NUM_BUS - 1)) rd_addr_q <= rd_addr_q + ADDR_W'(1);
          if (idx_q == IDX_W'(NUM_BUS)) begin
            state_q      <= S_LAUNCH;
            spi_go_q     <= 1'b1;
            spi_cs_sel_q <= cs_q;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        S_LAUNCH: begin
          state_q <= S_WAIT;
          wcnt_q  <= '0;
        end

        // Shifters may not raise busy until a cycle after SpiGo.
        S_WAIT: begin
          if (timeout_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if ((wcnt_q != '0) && shifters_idle_d) begin
            state_q <= S_GAP;
            gcnt_q  <= '0;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end

        S_GAP: begin
          if (gcnt_q == GCNT_W'(GAP_CYCLES - 1)) begin
            if (cs_q == 2'(NUM_CS - 1)) begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              state_q   <= S_LOAD;
              cs_q      <= cs_q + 2'd1;
              idx_q     <= '0;
              rd_addr_q <= slot_base(cs_q + 2'd1);
            end
          end else begin
            gcnt_q <= gcnt_q + GCNT_W'(1);
          end
        end

        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctl_if.RdAddr    = rd_addr_q;
  assign ctl_if.SpiData   = spi_data_q;
  assign ctl_if.SpiCsSel  = spi_cs_sel_q;
  assign ctl_if.SpiGo     = spi_go_q;
  assign ctl_if.Busy      = busy_q;
  assign ctl_if.FrameDone = frame_done_q;
  assign ctl_if.Fault     = fault_q;
  assign ctl_if.FaultCs   = fault_cs_q;
  assign ctl_if.Overrun   = overrun_q;

endmodule

// File: tb/tb_dm_spi_frame_sequencer.sv
// Scoreboard bench for dm_spi_frame_sequencer: expected launches and frame
// completions are queued by the stimulus and popped by an output monitor.
module tb_dm_spi_frame_sequencer;
  localparam int NUM_BUS        = 6;
  localparam int NUM_CS         = 4;
  localparam int DATA_W         = 24;
  localparam int ADDR_W         = 5;
  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 1024;

  logic clk  = 1'b0;
  logic nRst = 1'b1;
  always #5 clk = ~clk;

  dm_spi_frame_sequencer_if #(.NUM_BUS(NUM_BUS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

  dm_spi_frame_sequencer #(
    .NUM_BUS(NUM_BUS), .NUM_CS(NUM_CS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .ctl_if(sif)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] word(input int k);
    return DATA_W'(32'h100000 + k);
  endfunction

  // Channel buffer: registered read, data valid one cycle after the address.
  always @(posedge clk) sif.RdData <= word(int'(sif.RdAddr));

  // Shifter model: busy for 10 cycles after SpiGo, or bus 3 stuck in slot 1.
  bit busy_mode  = 1'b0;
  bit stuck_mode = 1'b0;
  bit stuck      = 1'b0;
  int bcnt       = 0;
  always @(posedge clk) begin
    if (busy_mode && sif.SpiGo) bcnt <= 10;
    else if (bcnt != 0)         bcnt <= bcnt - 1;
    if (!stuck_mode)                                      stuck <= 1'b0;
    else if (sif.SpiGo && sif.SpiCsSel == 2'd1)           stuck <= 1'b1;
  end
  assign sif.SpiBusy = {NUM_BUS{bcnt != 0}} | {2'b00, stuck, 3'b000};

  typedef struct {
    int                        t;
    logic [1:0]                cs;
    logic [NUM_BUS*DATA_W-1:0] data;
  } go_t;

  go_t               exp_go[$];
  int                exp_done[$];
  logic [ADDR_W-1:0] trace[$];
  bit                trace_en = 1'b0;
  go_t               mon_g;
  int                mon_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int t0, input int slot_len, input int nslots, input bit with_done);
    go_t g;
    for (int k = 0; k < nslots; k++) begin
      g.t  = t0 + NUM_BUS + 1 + k * slot_len;
      g.cs = 2'(k);
      for (int b = 0; b < NUM_BUS; b++) g.data[b*DATA_W +: DATA_W] = word(k * NUM_BUS + b);
      exp_go.push_back(g);
    end
    if (with_done) exp_done.push_back(t0 + NUM_CS * slot_len);
  endtask

  // Returns during the first cycle after the edge that samples Start (cycle t0).
  task automatic start_frame(output int t0);
    @(negedge clk);
    sif.Start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    sif.Start = 1'b0;
  endtask

  // Output monitor.
  always @(negedge clk) begin
    if (nRst && sif.SpiGo) begin
      if (exp_go.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_spigo: got SpiGo=1 cs=%0d at cycle %0d, required no launch", sif.SpiCsSel, cyc);
      end else begin
        mon_g = exp_go.pop_front();
        check("spigo_time", cyc, mon_g.t);
        check("spigo_cs", sif.SpiCsSel, mon_g.cs);
        check("spigo_data", sif.SpiData, mon_g.data);
      end
    end
    if (nRst && sif.FrameDone) begin
      if (exp_done.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_framedone: got FrameDone=1 at cycle %0d, required none", cyc);
      end else begin
        mon_t = exp_done.pop_front();
        check("framedone_time", cyc, mon_t);
        check("framedone_busy", sif.Busy, 1'b0);
      end
    end
    if (trace_en && sif.Busy && (trace.size() == 0 || sif.RdAddr != trace[$]))
      trace.push_back(sif.RdAddr);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int tf;
    sif.Start    = 1'b0;
    sif.ClrFlags = 1'b0;
    #2 nRst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", sif.SpiData, '0);
    check("reset_ctrl", {sif.RdAddr, sif.SpiCsSel, sif.SpiGo, sif.Busy, sif.FrameDone,
                         sif.Fault, sif.FaultCs, sif.Overrun}, '0);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", sif.Busy, 1'b0);

    // Shifters busy 10 cycles per slot: slot length 7+1+11+4 = 23.
    busy_mode = 1'b1;
    start_frame(t0);
    push_frame(t0, 23, 4, 1'b1);
    check("frame_busy", sif.Busy, 1'b1);
    repeat (100) @(negedge clk);
    check("p1_go_left", exp_go.size(), 0);
    check("p1_done_left", exp_done.size(), 0);
    check("p1_busy_end", sif.Busy, 1'b0);

    // Shifters never busy: minimum slot length 14, plus address trace.
    busy_mode = 1'b0;
    trace.delete();
    trace_en = 1'b1;
    start_frame(t0);
    push_frame(t0, 14, 4, 1'b1);
    check("p2_first_addr", sif.RdAddr, 5'd0);
    repeat (70) @(negedge clk);
    trace_en = 1'b0;
    check("p2_go_left", exp_go.size(), 0);
    check("p2_done_left", exp_done.size(), 0);
    check("trace_len", trace.size(), NUM_BUS * NUM_CS);
    for (int k = 0; k < trace.size() && k < NUM_BUS * NUM_CS; k++) check("trace_addr", trace[k], k);

    // Bus 3 stuck busy in slot 1: timeout after 1024 WAIT cycles.
    stuck_mode = 1'b1;
    start_frame(t0);
    push_frame(t0, 14, 2, 1'b0);
    tf = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (sif.Fault) begin
        tf = cyc;
        break;
      end
    end
    check("fault_time", tf, t0 + 21 + 1025);
    check("fault_flag", sif.Fault, 1'b1);
    check("fault_cs", sif.FaultCs, 2'd1);
    check("fault_busy", sif.Busy, 1'b0);
    check("fault_go_left", exp_go.size(), 0);
    stuck_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("fault_sticky", sif.Fault, 1'b1);
    sif.ClrFlags = 1'b1;
    @(negedge clk);
    sif.ClrFlags = 1'b0;
    check("fault_cleared", sif.Fault, 1'b0);

    // Start while busy: overrun, frame unaffected; set beats ClrFlags.
    start_frame(t0);
    push_frame(t0, 14, 4, 1'b1);
    check("overrun_before", sif.Overrun, 1'b0);
    sif.Start = 1'b1;
    @(negedge clk);
    sif.Start = 1'b0;
    check("overrun_set", sif.Overrun, 1'b1);
    repeat (10) @(negedge clk);
    sif.Start    = 1'b1;
    sif.ClrFlags = 1'b1;
    @(negedge clk);
    sif.Start    = 1'b0;
    sif.ClrFlags = 1'b0;
    check("overrun_set_wins", sif.Overrun, 1'b1);
    repeat (60) @(negedge clk);
    check("p4_go_left", exp_go.size(), 0);
    check("p4_done_left", exp_done.size(), 0);
    sif.ClrFlags = 1'b1;
    @(negedge clk);
    sif.ClrFlags = 1'b0;
    check("overrun_cleared", sif.Overrun, 1'b0);

    // Reset during WAIT of slot 2 (launch at t0+53), then a full clean frame.
    busy_mode = 1'b1;
    start_frame(t0);
    push_frame(t0, 23, 3, 1'b0);
    repeat (58) @(negedge clk);
    nRst = 1'b0;
    #1;
    check("midrst_data", sif.SpiData, '0);
    check("midrst_ctrl", {sif.RdAddr, sif.SpiCsSel, sif.SpiGo, sif.Busy, sif.FrameDone,
                          sif.Fault, sif.FaultCs, sif.Overrun}, '0);
    check("midrst_go_left", exp_go.size(), 0);
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    repeat (15) @(negedge clk);
    start_frame(t0);
    push_frame(t0, 23, 4, 1'b1);
    repeat (100) @(negedge clk);
    check("p5_go_left", exp_go.size(), 0);
    check("p5_done_left", exp_done.size(), 0);
    check("p5_busy_end", sif.Busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_spi_frame_sequencer.md
# dm_spi_frame_sequencer

Sequences one full deformable-mirror DAC update frame across the six SPI output buses (A–F), each with four chip selects. On a frame trigger it walks chip-select slots 0..3. For each slot it:
- fetches one DAC word per bus from the channel buffer RAM written over RamBus,
- launches all six SPI shifters in parallel,
- waits for completion, then inserts a deselect gap.

It sits between the RamBus-mapped channel buffer and the per-bus SPI shifters inside DMMainPorts. It replaces the tied-off nCs/Sck/Mosi outputs as their controller.

## Interface
- NUM_BUS, 6, parallel SPI buses
- NUM_CS, 4, chip-select slots per bus
- DATA_W, 24, DAC word width
- ADDR_W, 5, buffer address width (must hold NUM_BUS*NUM_CS-1)
- GAP_CYCLES, 4, deselect gap after each slot (≥1)
- TIMEOUT_CYCLES, 1024, max WAIT cycles before fault
- clk  in  1  system clock; one clock domain
- nRst  in  1  asynchronous, active-low reset
- Start  in  1  frame trigger (PPS-derived or register strobe), sampled high = request
- ClrFlags  in  1  clears Fault and Overrun
- RdAddr  out  ADDR_W  channel buffer read address, addr = cs*NUM_BUS + bus
- RdData  in  DATA_W  buffer read data, valid 1 cycle after RdAddr
- SpiData  out  NUM_BUS*DATA_W  per-bus words, bus b at [b*DATA_W +: DATA_W]
- SpiCsSel  out  2  active chip-select slot
- SpiGo  out  1  one-cycle launch pulse to all shifters
- SpiBusy  in  NUM_BUS  per-shifter busy
- Busy  out  1  frame in progress
- FrameDone  out  1  one-cycle pulse on a successful frame
- Fault  out  1  sticky; timeout occurred
- FaultCs  out  2  slot that timed out
- Overrun  out  1  sticky; Start seen while Busy

## Operation
- Reset values: RdAddr=0, SpiData=0, SpiCsSel=0, SpiGo=0, Busy=0, FrameDone=0, Fault=0, FaultCs=0, Overrun=0; state IDLE.
- IDLE: on Start=1, go to LOAD, set cs=0, Busy=1.
- LOAD: present RdAddr = cs*NUM_BUS + 0 .. cs*NUM_BUS + NUM_BUS-1 on consecutive cycles. Capture RdData into bus slot b one cycle after its address. After the last capture, go to LAUNCH.
- LAUNCH: SpiGo=1 for exactly one cycle, with SpiCsSel=cs, then go to WAIT.
- WAIT: ignore SpiBusy in the first WAIT cycle. From the second cycle on, go to GAP when SpiBusy == 0. Count WAIT cycles; if the count reaches TIMEOUT_CYCLES with SpiBusy ≠ 0:
  - set Fault=1 and FaultCs=cs,
  - return to IDLE, Busy=0, no FrameDone.
- GAP: hold for GAP_CYCLES cycles. Then, if cs == NUM_CS-1, go to DONE; else cs++ and go to LOAD.
- DONE: FrameDone=1 for one cycle, Busy=0 in the same cycle, then IDLE.
- SpiData and SpiCsSel hold from LAUNCH until the next LOAD overwrites them. They are never changed while a shifter may be shifting.
- Start while Busy=1: ignored; Overrun=1. Start in the DONE cycle also counts as overrun. A new frame starts only from IDLE.
- ClrFlags clears Fault and Overrun. If a set event and ClrFlags occur in the same cycle, set wins.
- Fault does not block later frames.
- Address arithmetic is unsigned with no wrap; the maximum address is NUM_BUS*NUM_CS-1 = 23.

## Timing
- Start sampled at edge N:
  - Busy=1 and RdAddr=cs*NUM_BUS during cycle N+1.
  - RdAddr advances by 1 per cycle through cycle N+NUM_BUS.
  - Last RdData is captured at the end of cycle N+NUM_BUS+1.
  - SpiGo is high during cycle N+NUM_BUS+2 (N+8 by default).
- Each following slot: SpiGo occurs NUM_BUS+2 cycles after GAP exits.
- Minimum slot length with SpiBusy low immediately: NUM_BUS+1 (LOAD) + 1 (LAUNCH) + 2 (WAIT) + GAP_CYCLES = 14 cycles by default.
- Reset mid-frame: all outputs return to reset values asynchronously. SpiGo is never glitched high, and no FrameDone is issued.

## Test plan
- Buffer word k = 0x100000+k, SpiBusy high 10 cycles after each SpiGo, Start pulse:
  - 4 SpiGo pulses with SpiCsSel 0,1,2,3,
  - slot 2 SpiData bus 5 = 0x100011,
  - one FrameDone, then Busy=0.
- SpiBusy tied 0: first SpiGo at N+8, successive SpiGo 14 cycles apart, FrameDone 14 cycles after the last SpiGo's slot start.
- SpiBusy[3] stuck high in slot 1: Fault=1 and FaultCs=1 after 1024 WAIT cycles, Busy=0, no FrameDone, only 2 SpiGo pulses; ClrFlags then clears Fault.
- Start pulsed again mid-frame: Overrun=1, the frame still completes with exactly 4 SpiGo. Start together with ClrFlags while Busy: Overrun remains 1.
- nRst asserted during WAIT of slot 2: all outputs immediately 0. After release, a Start runs a full frame from cs=0.
- RdAddr trace for one frame covers exactly 0..23 once each, in ascending order.
